// File: rtl/mux7_pkg.sv
// Shared constants, state type and select-stepping helper for the mux7 scan sequencer.
package mux7_pkg;

    localparam int NUM_IN   = 7;
    localparam int SEL_W    = 3;
    localparam int LAST_IDX = 6;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } scan_state_t;

    // Next mux select in scan order; callers never step past the end legs,
    // so the tied-off leg 7 is unreachable.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel,
                                                  input logic             msb_first);
        return msb_first ? (sel - 3'd1) : (sel + 3'd1);
    endfunction

endpackage

// File: rtl/mux7_step_div.sv
// Bit-period divider: counts cycles while enabled and flags the last cycle of each bit.
module mux7_step_div #(
    parameter int STEP_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [3:0] TC_VAL = 4'(STEP_DIV - 1);

    logic [3:0] cnt;

    assign tc = en && (cnt == TC_VAL);

    // Divider count: restart on a new word, wrap at the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tc) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/mux7x1.sv
// 7:1 bit multiplexer with the eighth select leg tied low.
module mux7x1 (
    input  logic [6:0] data,
    input  logic [2:0] sel,
    output logic       y
);

    // Select one data bit; code 7 is the dummy leg.
    always_comb begin
        y = 1'b0;
        if (sel != 3'd7) begin
            y = data[sel];
        end
    end

endmodule

// File: rtl/mux7_scan_seq.sv
// Serialises a 7-bit word by stepping an external 7:1 mux select and registering its output.
module mux7_scan_seq
    import mux7_pkg::*;
#(
    parameter int STEP_DIV  = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IN-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NUM_IN-1:0] mux_i,
    output logic [SEL_W-1:0]  mux_s,
    input  logic              mux_o,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy
);

    localparam logic [SEL_W-1:0] SEL_START = MSB_FIRST ? SEL_W'(LAST_IDX) : '0;
    localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(LAST_IDX);

    scan_state_t      state;
    scan_state_t      state_d;
    logic [SEL_W-1:0] idx;
    logic             tc;
    logic             step;
    logic             final_step;
    logic             accept;

    mux7_step_div #(
        .STEP_DIV(STEP_DIV)
    ) u_step_div (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accept),
        .en   (state == SHIFT),
        .tc   (tc)
    );

    // A bit is taken on the last cycle of its period; the seventh such step
    // is where a following word may be accepted without a gap.
    assign step       = (state == SHIFT) && tc;
    assign final_step = step && (idx == IDX_LAST);
    assign in_ready   = (state == IDLE) || final_step;
    assign accept     = in_valid && in_ready;
    assign busy       = (state == SHIFT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state: leave SHIFT after the last bit unless a word is reloaded.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (final_step && !accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Word hold, select stepping and serial output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_i     <= '0;
            mux_s     <= '0;
            idx       <= '0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            if (step) begin
                ser_bit   <= mux_o;
                ser_valid <= 1'b1;
                ser_last  <= (idx == IDX_LAST);
                // The select parks on its last leg rather than stepping past it.
                if (!final_step) begin
                    mux_s <= next_sel(mux_s, MSB_FIRST);
                    idx   <= idx + 3'd1;
                end
            end
            if (accept) begin
                mux_i <= in_data;
                mux_s <= SEL_START;
                idx   <= '0;
            end
        end
    end

endmodule

// File: doc/mux7_scan_seq.md
Name: mux7_scan_seq

Overview:
- Upstream sequencer for the 7:1 bit multiplexer (mux7x1): accepts a 7-bit word over a valid/ready handshake and holds it stable on the mux data inputs.
- Steps the mux select 0..6, one bit every STEP_DIV cycles, and registers the returned mux output as a serial bit stream with valid/last strobes.
- The mux itself is instantiated by the parent and is not part of this block: mux_i/mux_s go out to it, and its output returns on mux_o.

Parameters:
- STEP_DIV, 1, clock cycles per serial bit (legal range 1..15).
- MSB_FIRST, 0, 0: select order 0→6; 1: select order 6→0.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  7  word to serialise.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word this cycle.
- mux_i  output  7  held word, driven to the mux data inputs.
- mux_s  output  3  select, driven to the mux select input.
- mux_o  input  1  mux output (combinational return path).
- ser_bit  output  1  registered serial bit.
- ser_valid  output  1  one-cycle strobe qualifying ser_bit.
- ser_last  output  1  high with the ser_valid of bit 7 of 7.
- busy  output  1  high in SHIFT.

Behaviour:
- Reset values: state IDLE; mux_i=0, mux_s=0, ser_bit=0, ser_valid=0, ser_last=0, busy=0, div counter=0, bit index=0. Reset is asynchronous at any time, including mid-word; the partial word is discarded and no further ser_valid is produced.
- States: IDLE and SHIFT.
- in_ready is combinational: 1 in IDLE, 1 in SHIFT on the final-step cycle (index=6 and div=STEP_DIV-1), and 0 otherwise.
- Accept: on in_valid&&in_ready, mux_i<=in_data; mux_s<=(MSB_FIRST?6:0); index<=0; div<=0; state<=SHIFT.
- SHIFT: div increments each cycle. When div==STEP_DIV-1:
  - ser_bit<=mux_o, ser_valid<=1, ser_last<=(index==6), div<=0.
  - Select advances by ±1 (per MSB_FIRST), index+1.
- At index 6 and the step edge: if a new accept occurs in the same cycle, reload the word and stay in SHIFT (gapless). Otherwise go to IDLE. mux_s and mux_i hold their last values in IDLE.
- ser_valid and ser_last otherwise deassert the next cycle (single-cycle pulses).
- Latency: with STEP_DIV=1, accept at edge E0 gives the bits at E1..E7 and ser_last at E7. Throughput is 7 bits per 7·STEP_DIV cycles.
- mux_s never takes the value 7, so the mux's tied-off dummy leg is never selected.
- in_valid while in_ready=0 is ignored; no word is captured. in_data is sampled only at the accept edge; changes during SHIFT have no effect.
- mux_i is stable for the whole word, so mux_o settles within the cycle (single-cycle combinational path).

Decomposition:
- Shared package mux7_pkg:
  - Constants NUM_IN=7, SEL_W=3, LAST_IDX=6.
  - typedef scan_state_t {IDLE, SHIFT}.
- One natural sub-module: mux7_step_div, a 4-bit cycle counter with a terminal-count pulse, cleared on accept.
- The top-level FSM, registers, and handshake remain in mux7_scan_seq.
- The bench instantiates mux7x1 alongside the block and connects mux_i/mux_s/mux_o.

Test Plan:
- STEP_DIV=1, MSB_FIRST=0, accept 7'b1011001 at E0 → ser_bit 1,0,0,1,1,0,1 at E1..E7; mux_s 0..6; ser_last only at E7; in_ready=0 at E1..E5.
- MSB_FIRST=1, same word → ser_bit 1,0,1,1,0,0,1; mux_s 6→0.
- Back-to-back: in_valid held with 7'h7F then 7'h00 → 14 consecutive ser_valid, 7 ones then 7 zeros, no gap, ser_last at bits 7 and 14.
- STEP_DIV=3, word 7'h55 → ser_valid every 3rd cycle; bits 1,0,1,0,1,0,1; busy high for 21 cycles.
- in_valid with 7'h12 asserted during SHIFT (not the final step) → ignored; output stream equals the first word only.
- rst_n pulled low after bit 3 → all outputs 0 immediately, in_ready=1 after release; new word 7'h01 → bits 1,0,0,0,0,0,0.
